cam_pixel_capture: RTL
======================

CAM_PIXEL_CAPTURE -- requirements
Module: cam_pixel_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 320: pixels per line emitted.
REQ-002 SHALL have parameter V_LINES, default 240: lines per frame emitted.
REQ-003 SHALL have parameter WEN_HOLD, default 4: clk cycles w_en is held high per pixel (range 1..15).
REQ-004 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-006 SHALL have port cam_pclk  input  1: camera pixel clock, sampled as data.
REQ-007 SHALL have port cam_vsync  input  1: camera vsync, high during vertical blanking.
REQ-008 SHALL have port cam_href  input  1: camera line-valid.
REQ-009 SHALL have port cam_d  input  8: camera byte bus, RGB565 high byte first.
REQ-010 SHALL have port w_data  output  16: assembled pixel {hi,lo} for the frame buffer.
REQ-011 SHALL have port w_en  output  1: pixel-write level; the buffer acts on its rising edge.
REQ-012 SHALL have port vsync  output  1: synchronised cam_vsync for the buffer's pointer reset.
REQ-013 SHALL have port frame_done  output  1: one-cycle pulse after the last line of a frame.
REQ-014 SHALL have port err_flags  output  3: sticky {overrun, frame_short, line_odd}.
REQ-015 SHALL have port frame_count  output  16: completed frames (see REQ-031).

Function
REQ-016 SHALL pass cam_pclk, cam_vsync, cam_href and cam_d through two flop stages before any use; a third pclk stage SHALL detect pclk rise as stage2=1 and stage3=0.
REQ-017 SHALL sample href and data only on a detected pclk rise, from stage2; correct operation SHALL require clk >= 4x cam_pclk.
REQ-018 SHALL implement states SYNC, LINE_WAIT, BYTE_HI and BYTE_LO; reset SHALL enter SYNC.
REQ-019 In SYNC, a falling edge of synchronised vsync SHALL clear x and y and enter LINE_WAIT; all bytes before it SHALL be ignored.
REQ-020 In LINE_WAIT or BYTE_HI, a pclk rise with href=1 SHALL latch cam_d as the high byte and enter BYTE_LO.
REQ-021 In BYTE_LO, a pclk rise with href=1 SHALL form w_data={hi,cam_d} on the next clk, increment x and enter BYTE_HI.
REQ-022 In BYTE_HI, synchronised href falling SHALL set x=0, increment y and enter LINE_WAIT; when y reaches V_LINES, frame_done SHALL pulse once on that cycle and the block SHALL enter SYNC.
REQ-023 In BYTE_LO, href falling SHALL discard the half pixel, set line_odd, then behave as REQ-022.
REQ-024 A rising edge of synchronised vsync in any state other than SYNC SHALL enter SYNC; if y<V_LINES, frame_short SHALL be set.
REQ-025 Pixels with x>=H_PIXELS or y>=V_LINES SHALL NOT raise w_en, SHALL NOT change w_data and SHALL set overrun.
REQ-026 An emitted pixel SHALL raise w_en for exactly WEN_HOLD cycles, starting on the same cycle w_data updates; w_data SHALL be stable while w_en is high.
REQ-027 A pixel that completes while w_en is high or in the cycle after it falls SHALL be dropped and SHALL set overrun; x SHALL still increment.
REQ-028 vsync SHALL equal synchronised cam_vsync delayed so that its falling edge precedes the first w_en rise of a frame by at least 2 cycles.
REQ-029 err_flags SHALL be sticky until reset.

Reset
REQ-030 When rst_n=0 at a clk edge: state=SYNC, x=y=0, w_data=0, w_en=0, vsync=0, frame_done=0, err_flags=0, frame_count=0, synchroniser flops=0; a reset during a line SHALL abandon that line and SHALL emit no partial pixel.

Configuration
REQ-031 With macro CAM_PIXEL_CAPTURE_STATS_EN defined, frame_count SHALL increment, wrapping at 16 bits, on each frame_done pulse; without it, frame_count SHALL be constant 0 and no counter SHALL be built.

Verification
REQ-032 Scenario: after reset, one full 320x240 frame at pclk=clk/4 with byte pairs 0xF8,0x1F -> exactly 76800 w_en rising edges, each with w_data=0xF81F, one frame_done pulse, err_flags=0.
REQ-033 Scenario: stimulus starts mid-frame at line 100 -> no w_en until the next vsync fall, then 76800 pixels.
REQ-034 Scenario: one line of 641 bytes -> 320 pixels written, line_odd set; the next line is unaffected.
REQ-035 Scenario: vsync rises after 120 lines -> frame_short set, no frame_done; the next frame is captured complete.
REQ-036 Scenario: lines of 330 pixels -> 320 writes per line, overrun set.
REQ-037 Scenario: rst_n low for 1 cycle mid-line -> all outputs 0 the next cycle, no w_en until the next vsync fall; with CAM_PIXEL_CAPTURE_STATS_EN, 3 frames -> frame_count=3.

Source files
------------

// File: rtl/cam_pixel_capture.sv
// Captures an RGB565 camera byte stream (sampled as data on the system clock) and emits held pixel writes.
// Optional frame counter enabled by defining CAM_PIXEL_CAPTURE_STATS_EN.
module cam_pixel_capture #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int WEN_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_d,
    output logic [15:0] w_data,
    output logic        w_en,
    output logic        vsync,
    output logic        frame_done,
    output logic [2:0]  err_flags,
    output logic [15:0] frame_count
);
    localparam logic [15:0] H_MAX     = H_PIXELS[15:0];
    localparam logic [15:0] V_MAX     = V_LINES[15:0];
    localparam logic [3:0]  HOLD_INIT = 4'(WEN_HOLD - 1);

    typedef enum logic [1:0] {SYNC, LINE_WAIT, BYTE_HI, BYTE_LO} state_t;
    state_t r_state, w_state_next;

    logic       r_pclk_s1, r_pclk_s2, r_pclk_s3;
    logic       r_vs_s1, r_vs_s2, r_vs_d;
    logic       r_href_s1, r_href_s2, r_href_smp;
    logic [7:0] r_d_s1, r_d_s2, r_hi;
    logic [15:0] r_x, r_y;
    logic [3:0] r_hold;
    logic       r_cool;

    logic w_pclk_rise, w_vs_rise, w_vs_fall, w_href_hi, w_href_fall;
    logic w_start_frame, w_latch_hi, w_pixel_done, w_line_end, w_line_odd;
    logic w_frame_short, w_last_line, w_in_range, w_busy, w_emit, w_overrun;
    logic [15:0] w_y_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pclk_s1 <= 1'b0; r_pclk_s2 <= 1'b0; r_pclk_s3 <= 1'b0;
            r_vs_s1 <= 1'b0; r_vs_s2 <= 1'b0; r_vs_d <= 1'b0;
            r_href_s1 <= 1'b0; r_href_s2 <= 1'b0; r_href_smp <= 1'b0;
            r_d_s1 <= 8'd0; r_d_s2 <= 8'd0;
        end else begin
            r_pclk_s1 <= cam_pclk;  r_pclk_s2 <= r_pclk_s1; r_pclk_s3 <= r_pclk_s2;
            r_vs_s1   <= cam_vsync; r_vs_s2   <= r_vs_s1;   r_vs_d    <= r_vs_s2;
            r_href_s1 <= cam_href;  r_href_s2 <= r_href_s1;
            r_d_s1    <= cam_d;     r_d_s2    <= r_d_s1;
            // href history is kept in pclk time so a line end is seen only on a pclk rise
            if (w_pclk_rise)
                r_href_smp <= r_href_s2;
        end
    end

    assign w_pclk_rise = r_pclk_s2 & ~r_pclk_s3;
    assign w_vs_rise   = r_vs_s2 & ~r_vs_d;
    assign w_vs_fall   = ~r_vs_s2 & r_vs_d;
    assign w_href_hi   = w_pclk_rise & r_href_s2;
    assign w_href_fall = w_pclk_rise & ~r_href_s2 & r_href_smp;
    assign w_y_inc     = r_y + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= SYNC;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_start_frame = 1'b0;
        w_latch_hi    = 1'b0;
        w_pixel_done  = 1'b0;
        w_line_end    = 1'b0;
        w_line_odd    = 1'b0;
        w_frame_short = 1'b0;
        w_last_line   = 1'b0;
        if (r_state == SYNC) begin
            if (w_vs_fall) begin
                w_start_frame = 1'b1;
                w_state_next  = LINE_WAIT;
            end
        end else if (w_vs_rise) begin
            w_state_next  = SYNC;
            w_frame_short = (r_y < V_MAX);
        end else begin
            case (r_state)
                LINE_WAIT: if (w_href_hi) begin
                    w_latch_hi   = 1'b1;
                    w_state_next = BYTE_LO;
                end
                BYTE_HI: if (w_href_hi) begin
                    w_latch_hi   = 1'b1;
                    w_state_next = BYTE_LO;
                end else if (w_href_fall) begin
                    w_line_end = 1'b1;
                end
                BYTE_LO: if (w_href_hi) begin
                    w_pixel_done = 1'b1;
                    w_state_next = BYTE_HI;
                end else if (w_href_fall) begin
                    w_line_end = 1'b1;
                    w_line_odd = 1'b1;
                end
                default: ;
            endcase
            if (w_line_end) begin
                if (w_y_inc >= V_MAX) begin
                    w_last_line  = 1'b1;
                    w_state_next = SYNC;
                end else begin
                    w_state_next = LINE_WAIT;
                end
            end
        end
    end

    // One idle cycle after each write level keeps consecutive rising edges distinct for the buffer
    assign w_busy     = w_en | r_cool;
    assign w_in_range = (r_x < H_MAX) && (r_y < V_MAX);
    assign w_emit     = w_pixel_done & w_in_range & ~w_busy;
    assign w_overrun  = w_pixel_done & ~w_emit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x <= 16'd0; r_y <= 16'd0; r_hi <= 8'd0;
            w_data <= 16'd0; w_en <= 1'b0; r_hold <= 4'd0; r_cool <= 1'b0;
            vsync <= 1'b0; frame_done <= 1'b0; err_flags <= 3'd0;
        end else begin
            frame_done <= w_last_line;
            vsync      <= r_vs_d;
            if (w_start_frame) begin
                r_x <= 16'd0;
                r_y <= 16'd0;
            end else if (w_line_end) begin
                r_x <= 16'd0;
                r_y <= w_y_inc;
            end else if (w_pixel_done && r_x != 16'hFFFF) begin
                r_x <= r_x + 16'd1;
            end
            if (w_latch_hi)
                r_hi <= r_d_s2;
            if (w_emit) begin
                w_data <= {r_hi, r_d_s2};
                w_en   <= 1'b1;
                r_hold <= HOLD_INIT;
                r_cool <= 1'b0;
            end else if (w_en) begin
                if (r_hold == 4'd0) begin
                    w_en   <= 1'b0;
                    r_cool <= 1'b1;
                end else begin
                    r_hold <= r_hold - 4'd1;
                end
            end else begin
                r_cool <= 1'b0;
            end
            err_flags <= err_flags | {w_overrun, w_frame_short, w_line_odd};
        end
    end

`ifdef CAM_PIXEL_CAPTURE_STATS_EN
    logic [15:0] r_frame_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_frame_cnt <= 16'd0;
        else if (frame_done)
            r_frame_cnt <= r_frame_cnt + 16'd1;
    end
    assign frame_count = r_frame_cnt;
`else
    assign frame_count = 16'd0;
`endif
endmodule
